dm_arbiter: RTL
===============

# dm_arbiter

Round-robin arbiter that shares one single-port synchronous data memory (DM) among `NUM_CORES` processor cores. Each core's control unit issues one-word read/write requests. The arbiter serialises them onto the DM port and returns read data with a per-core valid strobe. A bounded lock lets one core hold the port for consecutive accesses, for example a read-modify-write.

## Interface
Parameters:
- `NUM_CORES`, 4 — number of requesting cores, 2..8.
- `ADDR_W`, 16 — DM address width.
- `DATA_W`, 16 — DM word width.
- `MAX_LOCK`, 4 — maximum consecutive grants to one locked core, ≥1.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `req`  in  NUM_CORES  — per-core access request.
- `we`  in  NUM_CORES  — per-core write enable: 1 = write, 0 = read.
- `lock`  in  NUM_CORES  — per-core request to keep the grant after the current access.
- `addr`  in  NUM_CORES*ADDR_W  — packed addresses; core i uses `[i*ADDR_W +: ADDR_W]`.
- `wdata`  in  NUM_CORES*DATA_W  — packed write data, same packing as `addr`.
- `gnt`  out  NUM_CORES  — one-hot; high during the cycle the core's access is on the DM port.
- `rvalid`  out  NUM_CORES  — one-hot; read data for that core is on `rdata`.
- `rdata`  out  DATA_W  — shared read data, equal to `mem_rdata`.
- `mem_en`  out  1  — DM access strobe.
- `mem_we`  out  1  — DM write strobe.
- `mem_addr`  out  ADDR_W  — DM address.
- `mem_wdata`  out  DATA_W  — DM write data.
- `mem_rdata`  in  DATA_W  — DM read data, valid one cycle after a read is issued.
- `busy`  out  1  — high when the arbiter is in HOLD state or any `gnt` bit is high.

## Operation
- Requester rule: core i holds `req[i]`, `we[i]`, `addr[i]` and `wdata[i]` stable until it sees `gnt[i]`. A core may drop `req` before it is granted; no grant is then issued for that request.
- Eligible set: `req & ~mask`. `mask` is the one-hot of the core granted in the current cycle. The one exception is a core in HOLD state, which is not masked.
- The state machine has two states: ARB and HOLD.
- ARB state:
  - Pick the first eligible core scanning upward, with wrap-around, from `rr_ptr`.
  - On the clock edge, register `gnt` and copy that core's `we`, `addr` and `wdata` onto `mem_*`, with `mem_en`=1.
  - Set `rr_ptr` = (winner+1) mod NUM_CORES.
  - If `lock[winner]`=1 at that edge, go to HOLD with `lock_cnt`=1.
  - If the eligible set is empty, all `gnt` bits are 0, `mem_en`=0, and `rr_ptr` is unchanged.
- HOLD state, with holder h:
  - If `req[h]` and `lock[h]` are both 1 and `lock_cnt` < MAX_LOCK, grant h again and increment `lock_cnt`.
  - Otherwise return to ARB: clear `lock_cnt` and arbitrate normally in the same decision, with h masked.
  - When `lock_cnt` reaches MAX_LOCK, the next decision forces ARB even if `lock[h]`=1.
- Reads: `rvalid[i]` is set one cycle after a cycle in which `gnt[i]`=1 and `mem_we`=0. `rdata` is passed through combinationally from `mem_rdata`.
- Writes: the write is committed by the DM on the edge that ends the `gnt` cycle. No response is returned.
- In cycles with no grant, `mem_addr` and `mem_wdata` keep their previous values. `mem_we` is 0 whenever `mem_en` is 0.
- Reset values: `gnt`=0, `rvalid`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `rr_ptr`=0, `lock_cnt`=0, state ARB.
- Reset mid-operation clears all state immediately. Pending `rvalid` strobes are dropped, and no DM access is issued until the first edge after `rst_n` is released.

## Timing
- Request sampled on edge E, so the core's access is on `mem_*` and `gnt` is high in the cycle after E (cycle t+1).
- Read data and `rvalid` are visible in cycle t+2. Read latency from request is therefore 2 cycles.
- Throughput is one access per cycle across cores. An unlocked single core gets at most one grant every 2 cycles because of the mask. A locked core gets up to MAX_LOCK back-to-back grants.
- Worst-case wait for an unlocked requester: (NUM_CORES−1)·MAX_LOCK grant cycles.
- `gnt`, `mem_*` and `rvalid` are all registered outputs. `rdata` is the only combinational output.

## Test plan
- Single read: core 2 reads addr 0x0010, with DM[0x0010]=0xBEEF → `gnt`=4'b0100 and `mem_addr`=0x0010 in t+1; `rvalid`=4'b0100 and `rdata`=0xBEEF in t+2.
- Full contention: all 4 `req` held high and continuously re-asserted, `lock`=0 → grant order 0,1,2,3,0,1 on consecutive cycles; no core granted twice in a row.
- Lock bound, MAX_LOCK=4: core 1 with `req`/`lock` high for 6 accesses, core 3 requesting throughout → `gnt[1]` for 4 consecutive cycles, then `gnt[3]`, then `gnt[1]` resumes.
- Lone unlocked core: core 0 with `req` held high → `gnt[0]` pulses every other cycle and `busy` toggles in step.
- Withdrawal and write: core 3 asserts `req` then drops it before being granted → no `gnt[3]`. Core 0 writes 0x1234 to 0x0020 → `mem_we`=1 for one cycle; a later read of 0x0020 returns 0x1234.
- Reset during a pending read: `rst_n` pulled low in cycle t+1 → all outputs 0 at once and no `rvalid` in t+2. After release, simultaneous requests from cores 1 and 2 → core 1 is granted first (`rr_ptr`=0).

Source files
------------

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one single-port DM among NUM_CORES cores, with bounded per-core lock.
// Grant and mem_* one cycle after the request edge, rvalid one cycle later; requesters wait (hold req) until granted.
module dm_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int MAX_LOCK  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CORES-1:0]          req,
   input  logic [NUM_CORES-1:0]          we,
   input  logic [NUM_CORES-1:0]          lock,
   input  logic [NUM_CORES*ADDR_W-1:0]   addr,
   input  logic [NUM_CORES*DATA_W-1:0]   wdata,
   output logic [NUM_CORES-1:0]          gnt,
   output logic [NUM_CORES-1:0]          rvalid,
   output logic [DATA_W-1:0]             rdata,
   output logic                          mem_en,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic [DATA_W-1:0]             mem_rdata,
   output logic                          busy
);

   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int CNT_W = $clog2(MAX_LOCK + 1);

   typedef enum logic {ST_ARB, ST_HOLD} state_t;

   state_t                 r_state;
   logic [IDX_W-1:0]       r_rr_ptr;
   logic [IDX_W-1:0]       r_holder;
   logic [CNT_W-1:0]       r_lock_cnt;
   logic [NUM_CORES-1:0]   r_gnt;
   logic [NUM_CORES-1:0]   r_rvalid;
   logic                   r_mem_en;
   logic                   r_mem_we;
   logic [ADDR_W-1:0]      r_mem_addr;
   logic [DATA_W-1:0]      r_mem_wdata;

   logic [NUM_CORES-1:0]   w_elig;
   logic                   w_found;
   logic [IDX_W-1:0]       w_win;
   int                     w_idx;
   logic                   w_hold_cont;
   logic                   w_grant;
   logic [IDX_W-1:0]       w_sel;
   logic [NUM_CORES-1:0]   w_sel_oh;
   state_t                 w_state_nxt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic [IDX_W-1:0]       w_ptr_nxt;
   logic [IDX_W-1:0]       w_holder_nxt;

   // The core on the port this cycle is masked, so an unlocked core cannot win twice in a row.
   // A holder that falls back to ARB is masked the same way, since it was granted this cycle.
   assign w_elig = req & ~r_gnt;

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = 0;
      for (int k = 0; k < NUM_CORES; k++) begin
         w_idx = int'(r_rr_ptr) + k;
         if (w_idx >= NUM_CORES) w_idx = w_idx - NUM_CORES;
         if (!w_found && w_elig[w_idx]) begin
            w_found = 1'b1;
            w_win   = IDX_W'(w_idx);
         end
      end
   end

   assign w_hold_cont = (r_state == ST_HOLD) && req[r_holder] && lock[r_holder]
                        && (r_lock_cnt < CNT_W'(MAX_LOCK));

   always_comb begin
      w_grant      = 1'b0;
      w_sel        = r_holder;
      w_state_nxt  = ST_ARB;
      w_cnt_nxt    = '0;
      w_ptr_nxt    = r_rr_ptr;
      w_holder_nxt = r_holder;
      if (w_hold_cont) begin
         w_grant     = 1'b1;
         w_state_nxt = ST_HOLD;
         w_cnt_nxt   = r_lock_cnt + 1'b1;
      end else if (w_found) begin
         w_grant   = 1'b1;
         w_sel     = w_win;
         w_ptr_nxt = (int'(w_win) == NUM_CORES - 1) ? '0 : w_win + 1'b1;
         if (lock[w_win]) begin
            w_state_nxt  = ST_HOLD;
            w_cnt_nxt    = CNT_W'(1);
            w_holder_nxt = w_win;
         end
      end
   end

   always_comb begin
      w_sel_oh        = '0;
      w_sel_oh[w_sel] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_ARB;
         r_rr_ptr    <= '0;
         r_holder    <= '0;
         r_lock_cnt  <= '0;
         r_gnt       <= '0;
         r_rvalid    <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rr_ptr   <= w_ptr_nxt;
         r_holder   <= w_holder_nxt;
         r_lock_cnt <= w_cnt_nxt;
         r_rvalid   <= r_mem_we ? '0 : r_gnt;
         if (w_grant) begin
            r_gnt       <= w_sel_oh;
            r_mem_en    <= 1'b1;
            r_mem_we    <= we[w_sel];
            r_mem_addr  <= addr[w_sel*ADDR_W +: ADDR_W];
            r_mem_wdata <= wdata[w_sel*DATA_W +: DATA_W];
         end else begin
            r_gnt    <= '0;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
         end
      end
   end

   assign gnt       = r_gnt;
   assign rvalid    = r_rvalid;
   assign rdata     = mem_rdata;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign busy      = (r_state == ST_HOLD) || (|r_gnt);

endmodule
